// File: rtl/shared_block_memory_pkg.sv
// Shared types and helpers for the multi-port block memory.
package shared_block_memory_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Bits needed to hold values 0..v-1, never less than one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational port arbiter: fixed priority (lowest index) or round-robin
// search starting just after the previously granted port.
module rr_arbiter
   import shared_block_memory_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MODE      = ARB_RR,
   parameter int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [GW-1:0]        last_grant,
   output logic [GW-1:0]        grant,
   output logic                 valid
);

   // i-th candidate in search order.
   function automatic logic [GW-1:0] port_at(input int i);
      int s;
      s = (MODE == ARB_RR) ? int'(last_grant) + 1 + i : i;
      return GW'(s % NUM_PORTS);
   endfunction

   // First requesting port in search order wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!valid && req[port_at(i)]) begin
            valid = 1'b1;
            grant = port_at(i);
         end
      end
   end

endmodule

// File: rtl/shared_block_memory.sv
// Multi-port block memory with configurable latency, one transaction in
// flight at a time, arbitrated fixed or round-robin across master ports.
module shared_block_memory
   import shared_block_memory_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int BLOCK_W    = 128,
   parameter int ADDR_W     = 28,
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 5,
   parameter int ARB_MODE   = ARB_RR
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic [NUM_PORTS-1:0]           READ,
   input  logic [NUM_PORTS-1:0]           WRITE,
   input  logic [NUM_PORTS*ADDR_W-1:0]    ADDRESS,
   input  logic [NUM_PORTS*BLOCK_W-1:0]   WRITEDATA,
   output logic [NUM_PORTS*BLOCK_W-1:0]   READDATA,
   output logic [NUM_PORTS-1:0]           BUSYWAIT
);

   localparam int GW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW    = clog2(LATENCY);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [NUM_PORTS-1:0]              req;
   logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_v;
   logic [NUM_PORTS-1:0][BLOCK_W-1:0] wdata_v;
   logic [NUM_PORTS-1:0][BLOCK_W-1:0] rdata_q;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [GW-1:0]           grant_q;
   logic [GW-1:0]           last_grant;
   logic [GW-1:0]           arb_grant;
   logic                    arb_valid;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic                    wr_q;
   logic                    rd_q;
   logic [BLOCK_W-1:0]      wdata_q;
   logic [BLOCK_W-1:0]      mem [DEPTH];

   // Upper address bits are deliberately ignored (aliasing).
   logic unused_addr;
   assign unused_addr = ^ADDRESS;

   assign req      = READ | WRITE;
   assign addr_v   = ADDRESS;
   assign wdata_v  = WRITEDATA;
   assign READDATA = rdata_q;

   // Only the granted port sees the stall drop, and only in DONE.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_bw
      assign BUSYWAIT[p] = req[p] && !(state == DONE && grant_q == GW'(p));
   end

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .MODE      (ARB_MODE),
      .GW        (GW)
   ) u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   // Transaction FSM: latch winner in IDLE, count down in ACCESS, ack in DONE.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         cnt        <= '0;
         grant_q    <= '0;
         last_grant <= GW'(NUM_PORTS - 1);
         idx_q      <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_q    <= arb_grant;
                  last_grant <= arb_grant;
                  idx_q      <= addr_v[arb_grant][DEPTH_LOG2-1:0];
                  wr_q       <= WRITE[arb_grant];
                  rd_q       <= READ[arb_grant];
                  wdata_q    <= wdata_v[arb_grant];
                  cnt        <= CW'(LATENCY - 1);
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  // Write wins over read; a combined request echoes the block.
                  if (wr_q) begin
                     mem[idx_q] <= wdata_q;
                     if (rd_q) rdata_q[grant_q] <= wdata_q;
                  end else begin
                     rdata_q[grant_q] <= mem[idx_q];
                  end
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_block_memory.sv
// Bench for shared_block_memory: a round-robin and a fixed-priority instance
// share the same request inputs; tasks follow whichever instance is selected.
module tb_shared_block_memory;

   localparam int NP  = 2;
   localparam int BW  = 128;
   localparam int AW  = 28;
   localparam int LAT = 5;

   logic              CLK;
   logic              RESET;
   logic [NP-1:0]     rd, wr;
   logic [NP*AW-1:0]  addr;
   logic [NP*BW-1:0]  wdata;
   logic [NP*BW-1:0]  rdata_r, rdata_f;
   logic [NP-1:0]     bw_r, bw_f;
   logic              sel_fx;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];

   typedef struct {
      int          port;
      logic        rd;
      logic        wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
      logic [BW-1:0] exp;
   } vec_t;
   vec_t tbl[10];

   shared_block_memory #(.NUM_PORTS(NP), .BLOCK_W(BW), .ADDR_W(AW), .DEPTH_LOG2(8),
                         .LATENCY(LAT), .ARB_MODE(1)) dut_rr (
      .CLK(CLK), .RESET(RESET), .READ(rd), .WRITE(wr), .ADDRESS(addr),
      .WRITEDATA(wdata), .READDATA(rdata_r), .BUSYWAIT(bw_r));

   shared_block_memory #(.NUM_PORTS(NP), .BLOCK_W(BW), .ADDR_W(AW), .DEPTH_LOG2(8),
                         .LATENCY(LAT), .ARB_MODE(0)) dut_fx (
      .CLK(CLK), .RESET(RESET), .READ(rd), .WRITE(wr), .ADDRESS(addr),
      .WRITEDATA(wdata), .READDATA(rdata_f), .BUSYWAIT(bw_f));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic chk_int(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   // One transaction on port p; called at posedge+1. Returns the cycle in
   // which BUSYWAIT dropped and how many sampled cycles it was high before.
   task automatic txn(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [BW-1:0] d, input logic [BW-1:0] exp,
                      output int done_cyc, output int hi);
      logic [NP-1:0]    b;
      logic [NP*BW-1:0] rv;
      logic [BW-1:0]    e;
      rd[p] = r;
      wr[p] = w;
      addr[p*AW +: AW]  = a;
      wdata[p*BW +: BW] = d;
      if (r) begin
         if (p == 0) q0.push_back(exp); else q1.push_back(exp);
      end
      hi = 0;
      done_cyc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         b = sel_fx ? bw_f : bw_r;
         if (!b[p]) begin
            done_cyc = cyc;
            break;
         end
         hi++;
      end
      if (done_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: port %0d never completed", p);
      end else if (r) begin
         rv = sel_fx ? rdata_f : rdata_r;
         e  = (p == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("rdata p%0d", p), rv[p*BW +: BW], e);
      end
      @(posedge CLK);
      #1;
      rd[p] = 1'b0;
      wr[p] = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   localparam logic [BW-1:0] DEAD = 128'hDEADBEEF_0123_4567_89AB_CDEF_CAFEF00D;
   localparam logic [BW-1:0] A5   = {4{32'hA5A5_5A5A}};
   localparam logic [BW-1:0] V55  = {4{32'h5555_5555}};
   localparam logic [BW-1:0] V12  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [BW-1:0] VA   = {4{32'hAAAA_AAAA}};

   initial begin
      int d0a, d0b, d0c, d1, h0, h1, hx;
      RESET  = 1'b1;
      rd     = '0;
      wr     = '0;
      addr   = '0;
      wdata  = '0;
      sel_fx = 1'b0;

      tbl[0] = '{1, 1'b0, 1'b1, 28'h0000105, A5,  128'h0};
      tbl[1] = '{1, 1'b1, 1'b0, 28'h0000005, 128'h0, A5};
      tbl[2] = '{0, 1'b1, 1'b0, 28'h0000105, 128'h0, A5};
      tbl[3] = '{0, 1'b1, 1'b1, 28'h0000030, V55, V55};
      tbl[4] = '{1, 1'b1, 1'b0, 28'h0000030, 128'h0, V55};
      tbl[5] = '{0, 1'b1, 1'b0, 28'hFFFFF30, 128'h0, V55};
      tbl[6] = '{1, 1'b1, 1'b0, 28'h0000044, 128'h0, 128'h0};
      tbl[7] = '{0, 1'b0, 1'b1, 28'h0000044, V12, 128'h0};
      tbl[8] = '{1, 1'b1, 1'b0, 28'h0000044, 128'h0, V12};
      tbl[9] = '{0, 1'b1, 1'b0, 28'h0000010, 128'h0, DEAD};

      // Reset state: stalls raised for requesters, read data cleared.
      #2 RESET = 1'b0;
      @(posedge CLK);
      #1 rd = 2'b11;
      @(negedge CLK);
      chk("bw_in_reset", {126'h0, bw_r}, {126'h0, 2'b11});
      chk("rdata_reset p0", rdata_r[BW-1:0], 128'h0);
      chk("rdata_reset p1", rdata_r[2*BW-1:BW], 128'h0);
      rd = 2'b00;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      // Single write, then an immediate repeat to show the one-cycle ack.
      txn(1, 1'b0, 1'b1, 28'h10, DEAD, 128'h0, d1, h1);
      chk_int("write_busy_cycles", h1, LAT + 1);
      txn(1, 1'b0, 1'b1, 28'h10, DEAD, 128'h0, d0a, hx);
      chk_int("b2b_busy_cycles", hx, LAT + 1);
      chk_int("b2b_spacing", d0a - d1, LAT + 2);

      // Table of single-port transactions, including aliasing and R+W.
      for (int i = 0; i < 10; i++) begin
         txn(tbl[i].port, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp, d0a, hx);
         chk_int($sformatf("latency row %0d", i), hx, LAT + 1);
      end

      // Round-robin: after reset port 0 wins, then port 1 before port 0's repeat.
      pulse_reset();
      fork
         begin
            txn(0, 1'b1, 1'b0, 28'h10, 128'h0, 128'h0, d0a, h0);
            txn(0, 1'b1, 1'b0, 28'h80, 128'h0, VA, d0b, h0);
         end
         txn(1, 1'b0, 1'b1, 28'h80, VA, 128'h0, d1, h1);
      join
      chk_int("rr p1 after p0", d1 - d0a, LAT + 2);
      chk_int("rr p0 repeat after p1", d0b - d1, LAT + 2);

      // Repeated collision: last grant was port 0, so port 1 goes first.
      fork
         txn(0, 1'b1, 1'b0, 28'h80, 128'h0, V12, d0a, h0);
         txn(1, 1'b0, 1'b1, 28'h80, V12, 128'h0, d1, h1);
      join
      chk_int("rr repeat p0 after p1", d0a - d1, LAT + 2);

      // Fixed priority: port 1 waits out three back-to-back port 0 writes.
      pulse_reset();
      sel_fx = 1'b1;
      fork
         begin
            txn(0, 1'b0, 1'b1, 28'h90, A5,  128'h0, d0a, h0);
            txn(0, 1'b0, 1'b1, 28'h90, V55, 128'h0, d0b, h0);
            txn(0, 1'b0, 1'b1, 28'h90, V12, 128'h0, d0c, h0);
         end
         txn(1, 1'b1, 1'b0, 28'h90, 128'h0, V12, d1, h1);
      join
      chk_int("fixed p0 spacing", d0c - d0a, 2 * (LAT + 2));
      chk_int("fixed p1 starved", d1 - d0c, LAT + 2);
      sel_fx = 1'b0;

      // Reset in the middle of a write: nothing commits.
      pulse_reset();
      wr[1] = 1'b1;
      addr[AW +: AW]  = 28'h20;
      wdata[BW +: BW] = VA;
      repeat (3) @(posedge CLK);
      #2 RESET = 1'b0;
      @(negedge CLK);
      chk("bw_mid_reset", {127'h0, bw_r[1]}, 128'h1);
      wr[1] = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      txn(0, 1'b1, 1'b0, 28'h20, 128'h0, 128'h0, d0a, hx);
      chk_int("after_reset latency", hx, LAT + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
